// File: rtl/ase_pcie_ss_pkg.sv
// Shared ASE PCIe SS definitions: parameter config, read-completion descriptor
// and FSM state type for the read-completion splitter.
package ase_pcie_ss_pkg;

   typedef struct packed {
      int unsigned max_payload_bytes;
      int unsigned req_cpl_boundary;
      int unsigned max_outstanding_dma_rd_reqs;
   } t_ase_pcie_ss_param_cfg;

   localparam t_ase_pcie_ss_param_cfg ASE_PCIE_SS_PARAMS = '{
      max_payload_bytes:           256,
      req_cpl_boundary:            64,
      max_outstanding_dma_rd_reqs: 256
   };

   localparam int unsigned ASE_PCIE_SS_MAX_RD_REQ_BYTES = 4096;
   // Widest tag the descriptor can carry; narrower tags are zero-extended.
   localparam int unsigned ASE_PCIE_SS_MAX_TAG_W = 16;

   typedef struct packed {
      logic [ASE_PCIE_SS_MAX_TAG_W-1:0] tag;
      logic [63:0]                      addr;
      logic [12:0]                      len;
      logic [12:0]                      byte_count;
      logic [6:0]                       lower_addr;
      logic                             first;
      logic                             last;
   } t_ase_pcie_ss_rd_cpl_desc;

   typedef enum logic {
      ASE_PCIE_SS_RD_CPL_IDLE,
      ASE_PCIE_SS_RD_CPL_SPLIT
   } t_ase_pcie_ss_rd_cpl_state;

endpackage

// File: rtl/ase_pcie_ss_rd_cpl_chunk_calc.sv
// Completion chunk sizing: largest payload up to MPS that ends on an RCB
// boundary, clipped to the bytes still owed.
module ase_pcie_ss_rd_cpl_chunk_calc #(
   parameter int unsigned MAX_PAYLOAD_BYTES = 256,
   parameter int unsigned REQ_CPL_BOUNDARY  = 64,
   localparam int unsigned RCB_W            = $clog2(REQ_CPL_BOUNDARY)
) (
   input  logic [RCB_W-1:0] cur_addr_off_i,
   input  logic [12:0]      remaining_i,
   output logic [12:0]      chunk_len_o,
   output logic             last_o
);

   logic [12:0] space;

   assign space = 13'(MAX_PAYLOAD_BYTES) - {{(13-RCB_W){1'b0}}, cur_addr_off_i};

   always_comb begin
      chunk_len_o = (remaining_i < space) ? remaining_i : space;
      last_o      = (chunk_len_o == remaining_i);
   end

endmodule

// File: rtl/ase_pcie_ss_rd_cpl_splitter.sv
// Splits accepted DMA read requests into MPS/RCB-compliant completion
// descriptors; drops zero-length, oversize and 4 KB-crossing requests.
module ase_pcie_ss_rd_cpl_splitter
   import ase_pcie_ss_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD_BYTES           = ASE_PCIE_SS_PARAMS.max_payload_bytes,
   parameter int unsigned REQ_CPL_BOUNDARY            = ASE_PCIE_SS_PARAMS.req_cpl_boundary,
   parameter int unsigned MAX_OUTSTANDING_DMA_RD_REQS = ASE_PCIE_SS_PARAMS.max_outstanding_dma_rd_reqs,
   localparam int unsigned TAG_W                      = $clog2(MAX_OUTSTANDING_DMA_RD_REQS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [TAG_W-1:0]  req_tag,
   input  logic [63:0]       req_addr,
   input  logic [12:0]       req_len_bytes,
   output logic              cpl_valid,
   input  logic              cpl_ready,
   output logic [TAG_W-1:0]  cpl_tag,
   output logic [63:0]       cpl_addr,
   output logic [12:0]       cpl_len_bytes,
   output logic [12:0]       cpl_byte_count,
   output logic [6:0]        cpl_lower_addr,
   output logic              cpl_first,
   output logic              cpl_last,
   output logic              err_req,
   output logic              busy
);

   localparam int unsigned RCB_W = $clog2(REQ_CPL_BOUNDARY);

   t_ase_pcie_ss_rd_cpl_state state_q, state_d;
   t_ase_pcie_ss_rd_cpl_desc  desc_q, desc_d;
   logic                      err_q, err_d;
   logic                      init_q;
   logic                      req_hs, cpl_hs, req_illegal;
   logic [13:0]               req_end;
   logic [63:0]               calc_addr;
   logic [12:0]               calc_rem, calc_len;
   logic                      calc_last;

   assign req_end     = {2'b00, req_addr[11:0]} + {1'b0, req_len_bytes};
   assign req_illegal = (req_len_bytes == '0)
                     || (req_len_bytes > 13'(ASE_PCIE_SS_MAX_RD_REQ_BYTES))
                     || (req_end > 14'(ASE_PCIE_SS_MAX_RD_REQ_BYTES));

   assign req_ready = init_q && (state_q == ASE_PCIE_SS_RD_CPL_IDLE);
   assign cpl_valid = (state_q == ASE_PCIE_SS_RD_CPL_SPLIT);
   assign busy      = cpl_valid;
   assign req_hs    = req_valid && req_ready;
   assign cpl_hs    = cpl_valid && cpl_ready;

   // The registered descriptor doubles as cur_addr/remaining; the single chunk
   // calculator sizes the *next* descriptor so cpl_* leave straight from flops.
   always_comb begin
      calc_addr = req_addr;
      calc_rem  = req_len_bytes;
      if (state_q == ASE_PCIE_SS_RD_CPL_SPLIT) begin
         calc_addr = desc_q.addr + 64'(desc_q.len);
         calc_rem  = desc_q.byte_count - desc_q.len;
      end
   end

   ase_pcie_ss_rd_cpl_chunk_calc #(
      .MAX_PAYLOAD_BYTES (MAX_PAYLOAD_BYTES),
      .REQ_CPL_BOUNDARY  (REQ_CPL_BOUNDARY)
   ) u_chunk_calc (
      .cur_addr_off_i (calc_addr[RCB_W-1:0]),
      .remaining_i    (calc_rem),
      .chunk_len_o    (calc_len),
      .last_o         (calc_last)
   );

   always_comb begin
      state_d = state_q;
      desc_d  = desc_q;
      err_d   = 1'b0;
      unique case (state_q)
         ASE_PCIE_SS_RD_CPL_IDLE: begin
            if (req_hs) begin
               if (req_illegal) begin
                  err_d = 1'b1;
               end else begin
                  state_d           = ASE_PCIE_SS_RD_CPL_SPLIT;
                  desc_d.tag        = ASE_PCIE_SS_MAX_TAG_W'(req_tag);
                  desc_d.addr       = calc_addr;
                  desc_d.len        = calc_len;
                  desc_d.byte_count = calc_rem;
                  desc_d.lower_addr = calc_addr[6:0];
                  desc_d.first      = 1'b1;
                  desc_d.last       = calc_last;
               end
            end
         end
         ASE_PCIE_SS_RD_CPL_SPLIT: begin
            if (cpl_hs) begin
               if (desc_q.last) begin
                  state_d = ASE_PCIE_SS_RD_CPL_IDLE;
                  desc_d  = '0;
               end else begin
                  desc_d.addr       = calc_addr;
                  desc_d.len        = calc_len;
                  desc_d.byte_count = calc_rem;
                  desc_d.lower_addr = calc_addr[6:0];
                  desc_d.first      = 1'b0;
                  desc_d.last       = calc_last;
               end
            end
         end
         default: begin
            state_d = ASE_PCIE_SS_RD_CPL_IDLE;
            desc_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ASE_PCIE_SS_RD_CPL_IDLE;
         desc_q  <= '0;
         err_q   <= 1'b0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         desc_q  <= desc_d;
         err_q   <= err_d;
         init_q  <= 1'b1;
      end
   end

   assign cpl_tag        = desc_q.tag[TAG_W-1:0];
   assign cpl_addr       = desc_q.addr;
   assign cpl_len_bytes  = desc_q.len;
   assign cpl_byte_count = desc_q.byte_count;
   assign cpl_lower_addr = desc_q.lower_addr;
   assign cpl_first      = desc_q.first;
   assign cpl_last       = desc_q.last;
   assign err_req        = err_q;

endmodule

// File: doc/ase_pcie_ss_rd_cpl_splitter.md
# ase_pcie_ss_rd_cpl_splitter

Host-side read-completion generator for the ASE PCIe SS emulation. It sits directly downstream of the AFU DMA read-request decode and upstream of the completion TLP formatter. Each accepted DMA read request becomes a sequence of completion descriptors that obey the configured max payload and read completion boundary (RCB). It also rejects malformed requests.

## Interface
- MAX_PAYLOAD_BYTES, 256, max completion payload; power of two, ≥ REQ_CPL_BOUNDARY
- REQ_CPL_BOUNDARY, 64, RCB in bytes; power of two, ≥ 4
- MAX_OUTSTANDING_DMA_RD_REQS, 256, tag range; TAG_W = $clog2 of this value
- clk  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accept
- req_tag  in  TAG_W  request tag
- req_addr  in  64  byte address
- req_len_bytes  in  13  request length, 1..4096
- cpl_valid  out  1  descriptor present
- cpl_ready  in  1  downstream accept
- cpl_tag  out  TAG_W  tag of the owning request
- cpl_addr  out  64  chunk start address
- cpl_len_bytes  out  13  chunk payload length
- cpl_byte_count  out  13  bytes remaining, including this chunk (PCIe Byte Count)
- cpl_lower_addr  out  7  cpl_addr[6:0]
- cpl_first  out  1  first chunk of the request
- cpl_last  out  1  final chunk; the request is complete
- err_req  out  1  one-cycle pulse when a request is dropped
- busy  out  1  a request is being split

## Operation
- States: IDLE and SPLIT.
- IDLE
  - req_ready=1.
  - On a handshake, validate the request. It is illegal if len_bytes==0, len_bytes>4096, or addr[11:0]+len_bytes>4096 (4 KB crossing).
  - Illegal request: pulse err_req the next cycle, stay in IDLE, emit no descriptor.
  - Legal request: load tag, cur_addr, remaining=len_bytes; set first=1; go to SPLIT.
- SPLIT
  - req_ready=0.
  - chunk_len = min(remaining, MAX_PAYLOAD_BYTES − (cur_addr mod REQ_CPL_BOUNDARY)). Every non-final chunk therefore ends on an RCB boundary.
  - Descriptor fields: cpl_addr=cur_addr, cpl_len_bytes=chunk_len, cpl_byte_count=remaining, cpl_last=(chunk_len==remaining).
  - On a cpl handshake: cur_addr += chunk_len, remaining −= chunk_len, first cleared.
  - If the handshaked chunk had cpl_last set, return to IDLE.
- Arithmetic
  - remaining and chunk_len are 13 bits.
  - The address add is 64-bit. It never carries past bit 11 within a request, because 4 KB crossing is rejected.
- busy = (state==SPLIT).
- The tag value is passed through unchecked. Tag range is the consumer's concern.

## Timing
- Reset values: req_ready=0 while rst_n low, 1 from the first clock after deassertion. All other outputs are 0.
- The first descriptor is valid in the cycle after request acceptance.
- One descriptor per cycle while cpl_ready=1.
- cpl_* outputs are registered. They hold stable while cpl_valid=1 and cpl_ready=0.
- cpl_valid never drops without a handshake.
- After the last-chunk handshake there is one IDLE cycle with req_ready=1. The minimum request-to-request spacing is chunks+1 cycles.
- err_req fires one cycle after the illegal handshake. A following request may be accepted in that same cycle.
- Reset assertion mid-SPLIT:
  - the in-flight request is abandoned immediately;
  - cpl_valid drops asynchronously;
  - no descriptor is emitted after reset.

## Structure
- Shared package ase_pcie_ss_pkg holds:
  - the existing parameter config struct (source of the three parameters);
  - a new descriptor struct t_ase_pcie_ss_rd_cpl_desc (tag, addr, len, byte_count, lower_addr, first, last);
  - the constant ASE_PCIE_SS_MAX_RD_REQ_BYTES=4096.
- Sub-module: ase_pcie_ss_rd_cpl_chunk_calc, purely combinational (cur_addr, remaining → chunk_len, last). It is instantiated once.

## Test plan
- MPS=256, RCB=64; req addr 0x1030, len 600, tag 5 → three descriptors:
  - 0x1030 len 208 bc 600 first;
  - 0x1100 len 256 bc 392;
  - 0x1200 len 136 bc 136 last, tag 5 on all.
- Req addr 0x2000, len 64 → one descriptor: len 64, bc 64, first=last=1, lower_addr 0x00. req_ready returns 2 cycles after acceptance.
- Req addr 0x3000, len 4096 → 16 descriptors of 256 B at 0x3000..0x3F00. Only the 16th has last=1; bc decrements 4096→256.
- Req with len 0, then addr 0x0FC0 with len 128 (4 KB crossing) → err_req pulses twice, no cpl_valid, busy stays 0.
- During the second chunk of case 1, hold cpl_ready low 3 cycles → cpl_* stable across the stall, then the sequence resumes unchanged.
- Assert rst_n low mid-SPLIT, then issue a new request → all outputs 0 during reset, and only the new request's descriptors appear afterwards.
